// File: rtl/mips_bp_pkg.sv
// Shared widths, counter constants and helpers for the MIPS branch target buffer.
// The optional MIPS_BP_STATS_EN build adds saturating statistics counters in the top.
package mips_bp_pkg;

  function automatic int idx_width(input int entries);
    return $clog2(entries);
  endfunction

  function automatic int tag_width(input int pc_w, input int entries);
    return pc_w - 2 - $clog2(entries);
  endfunction

  // Saturation ceiling of a ctr_w-bit direction counter.
  function automatic int unsigned ctr_max(input int ctr_w);
    return (32'd1 << ctr_w) - 32'd1;
  endfunction

  // Freshly allocated entries start weakly taken.
  function automatic int unsigned ctr_init(input int ctr_w);
    return 32'd1 << (ctr_w - 1);
  endfunction

  localparam logic [31:0] STAT_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/mips_bp_sat_ctr.sv
// Next-state logic of a CTR_W-bit up/down counter that saturates at 0 and at all-ones.
module mips_bp_sat_ctr
  import mips_bp_pkg::*;
#(
  parameter int CTR_W = 2
) (
  input  logic [CTR_W-1:0] ctr,
  input  logic             inc,
  output logic [CTR_W-1:0] ctr_next
);

  localparam logic [CTR_W-1:0] CTR_MAX = CTR_W'(ctr_max(CTR_W));

  always_comb begin
    ctr_next = ctr;
    if (inc) begin
      if (ctr != CTR_MAX) ctr_next = ctr + 1'b1;
    end else if (ctr != '0) begin
      ctr_next = ctr - 1'b1;
    end
  end

endmodule

// File: rtl/mips_branch_predictor.sv
// Direct-mapped BTB with 2-bit style direction counters: IF-stage lookup, MEM-stage update.
// Define MIPS_BP_STATS_EN to build the resolved-branch / mispredict statistics counters.
module mips_branch_predictor
  import mips_bp_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int PC_W    = 32,
  parameter int CTR_W   = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            bp_clear,
  input  logic [PC_W-1:0] lk_pc,
  output logic            lk_taken,
  output logic [PC_W-1:0] lk_next_pc,
  input  logic            upd_valid,
  input  logic [PC_W-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [PC_W-1:0] upd_target,
  input  logic            upd_pred_taken,
  input  logic [PC_W-1:0] upd_pred_target,
  output logic            mispredict,
  output logic [PC_W-1:0] redirect_pc,
  output logic [31:0]     stat_updates,
  output logic [31:0]     stat_mispredicts
);

  localparam int IDX_W = idx_width(ENTRIES);
  localparam int TAG_W = tag_width(PC_W, ENTRIES);
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(ctr_init(CTR_W));

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [PC_W-1:0]  target;
    logic [CTR_W-1:0] ctr;
  } bp_entry_t;

  // Flop array: needs an asynchronous read port for IF plus a one-cycle bulk clear.
  bp_entry_t table_reg [ENTRIES];

  // ---------------- lookup (reads pre-update state) ----------------
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  bp_entry_t        lk_entry;
  logic             lk_hit;

  assign lk_idx     = lk_pc[IDX_W+1:2];
  assign lk_tag     = lk_pc[PC_W-1:IDX_W+2];
  assign lk_entry   = table_reg[lk_idx];
  assign lk_hit     = lk_entry.valid && (lk_entry.tag == lk_tag);
  assign lk_taken   = lk_hit && lk_entry.ctr[CTR_W-1];
  assign lk_next_pc = lk_taken ? lk_entry.target : lk_pc + PC_W'(4);

  // ---------------- resolution / redirect ----------------
  assign mispredict  = upd_valid &&
                       ((upd_taken != upd_pred_taken) ||
                        (upd_taken && (upd_target != upd_pred_target)));
  assign redirect_pc = (upd_valid && upd_taken) ? upd_target : upd_pc + PC_W'(4);

  // ---------------- update path ----------------
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  bp_entry_t        upd_entry;
  logic             upd_hit;
  logic [CTR_W-1:0] ctr_next;
  bp_entry_t        upd_wr_entry;
  logic             upd_wr_en;

  assign upd_idx   = upd_pc[IDX_W+1:2];
  assign upd_tag   = upd_pc[PC_W-1:IDX_W+2];
  assign upd_entry = table_reg[upd_idx];
  assign upd_hit   = upd_entry.valid && (upd_entry.tag == upd_tag);

  mips_bp_sat_ctr #(
    .CTR_W (CTR_W)
  ) u_sat_ctr (
    .ctr      (upd_entry.ctr),
    .inc      (upd_taken),
    .ctr_next (ctr_next)
  );

  always_comb begin
    upd_wr_entry = upd_entry;
    upd_wr_en    = 1'b0;
    if (upd_valid) begin
      if (upd_hit) begin
        upd_wr_en        = 1'b1;
        upd_wr_entry.ctr = ctr_next;
        if (upd_taken) upd_wr_entry.target = upd_target;
      end else if (upd_taken) begin
        // Taken miss replaces whatever aliased into this slot.
        upd_wr_en           = 1'b1;
        upd_wr_entry.valid  = 1'b1;
        upd_wr_entry.tag    = upd_tag;
        upd_wr_entry.target = upd_target;
        upd_wr_entry.ctr    = CTR_INIT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) table_reg[i] <= '0;
    end else if (bp_clear) begin
      for (int i = 0; i < ENTRIES; i++) table_reg[i].valid <= 1'b0;
    end else if (upd_wr_en) begin
      table_reg[upd_idx] <= upd_wr_entry;
    end
  end

  // ---------------- statistics ----------------
`ifdef MIPS_BP_STATS_EN
  logic [31:0] stat_updates_reg;
  logic [31:0] stat_mispredicts_reg;

  // Counts survive bp_clear; only rst zeroes them.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_updates_reg     <= '0;
      stat_mispredicts_reg <= '0;
    end else begin
      if (upd_valid && (stat_updates_reg != STAT_MAX))
        stat_updates_reg <= stat_updates_reg + 32'd1;
      if (mispredict && (stat_mispredicts_reg != STAT_MAX))
        stat_mispredicts_reg <= stat_mispredicts_reg + 32'd1;
    end
  end

  assign stat_updates     = stat_updates_reg;
  assign stat_mispredicts = stat_mispredicts_reg;
`else
  assign stat_updates     = 32'h0;
  assign stat_mispredicts = 32'h0;
`endif

endmodule

// File: tb/tb_mips_branch_predictor.sv
// Directed bench for mips_branch_predictor: a per-slot PC-arithmetic model is compared every
// cycle, and literal expectations from the hand-worked scenarios pin the model.
module tb_mips_branch_predictor;

  localparam int ENTRIES  = 16;
  localparam int PC_W     = 32;
  localparam int CTR_W    = 2;
  localparam int IDX_BITS = 4;
  localparam int CTR_TOP  = 3;
  localparam int CTR_HALF = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            bp_clear;
  logic [PC_W-1:0] lk_pc;
  logic            lk_taken;
  logic [PC_W-1:0] lk_next_pc;
  logic            upd_valid;
  logic [PC_W-1:0] upd_pc;
  logic            upd_taken;
  logic [PC_W-1:0] upd_target;
  logic            upd_pred_taken;
  logic [PC_W-1:0] upd_pred_target;
  logic            mispredict;
  logic [PC_W-1:0] redirect_pc;
  logic [31:0]     stat_updates;
  logic [31:0]     stat_mispredicts;

  mips_branch_predictor #(
    .ENTRIES (ENTRIES),
    .PC_W    (PC_W),
    .CTR_W   (CTR_W)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .bp_clear         (bp_clear),
    .lk_pc            (lk_pc),
    .lk_taken         (lk_taken),
    .lk_next_pc       (lk_next_pc),
    .upd_valid        (upd_valid),
    .upd_pc           (upd_pc),
    .upd_taken        (upd_taken),
    .upd_target       (upd_target),
    .upd_pred_taken   (upd_pred_taken),
    .upd_pred_target  (upd_pred_target),
    .mispredict       (mispredict),
    .redirect_pc      (redirect_pc),
    .stat_updates     (stat_updates),
    .stat_mispredicts (stat_mispredicts)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- behavioural model ----------------
  bit          started = 0;
  bit          m_valid  [ENTRIES];
  int unsigned m_tag    [ENTRIES];
  logic [31:0] m_target [ENTRIES];
  int          m_ctr    [ENTRIES];
  logic [31:0] m_upd;
  logic [31:0] m_mis;

  function automatic int m_idx(input logic [31:0] pc);
    return int'((pc / 4) % ENTRIES);
  endfunction

  function automatic int unsigned m_tagof(input logic [31:0] pc);
    return pc / (4 * ENTRIES);
  endfunction

  function automatic bit model_mp();
    if (!upd_valid) return 1'b0;
    if (upd_taken != upd_pred_taken) return 1'b1;
    return upd_taken && (upd_target != upd_pred_target);
  endfunction

  function automatic logic [31:0] stat_view(input logic [31:0] v);
`ifdef MIPS_BP_STATS_EN
    return v;
`else
    return 32'h0 & v;
`endif
  endfunction

  always @(posedge clk) begin
    int ui;
    if (rst) begin
      started <= 1'b1;
      for (int i = 0; i < ENTRIES; i++) begin
        m_valid[i]  <= 1'b0;
        m_tag[i]    <= 0;
        m_target[i] <= 32'h0;
        m_ctr[i]    <= 0;
      end
      m_upd <= 32'h0;
      m_mis <= 32'h0;
    end else begin
      if (upd_valid && m_upd != 32'hFFFF_FFFF) m_upd <= m_upd + 32'd1;
      if (model_mp() && m_mis != 32'hFFFF_FFFF) m_mis <= m_mis + 32'd1;
      ui = m_idx(upd_pc);
      if (bp_clear) begin
        for (int i = 0; i < ENTRIES; i++) m_valid[i] <= 1'b0;
      end else if (upd_valid) begin
        if (m_valid[ui] && m_tag[ui] == m_tagof(upd_pc)) begin
          if (upd_taken) begin
            m_ctr[ui]    <= (m_ctr[ui] + 1 > CTR_TOP) ? CTR_TOP : m_ctr[ui] + 1;
            m_target[ui] <= upd_target;
          end else begin
            m_ctr[ui] <= (m_ctr[ui] - 1 < 0) ? 0 : m_ctr[ui] - 1;
          end
        end else if (upd_taken) begin
          m_valid[ui]  <= 1'b1;
          m_tag[ui]    <= m_tagof(upd_pc);
          m_target[ui] <= upd_target;
          m_ctr[ui]    <= CTR_HALF;
        end
      end
    end
  end

  // ---------------- literal expectations set by the stimulus ----------------
  bit          lit_lk_en = 0, lit_mp_en = 0, lit_st_en = 0;
  logic        lit_lk_taken, lit_mp;
  logic [31:0] lit_lk_next, lit_redir, lit_st_upd, lit_st_mis;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Single compare process: model on every cycle, literals when armed.
  always @(negedge clk) begin
    int          li;
    bit          hit;
    logic        e_taken;
    logic [31:0] e_next, e_redir;
    if (started) begin
      li      = m_idx(lk_pc);
      hit     = m_valid[li] && (m_tag[li] == m_tagof(lk_pc));
      e_taken = hit && (m_ctr[li] >= CTR_HALF);
      e_next  = e_taken ? m_target[li] : lk_pc + 32'd4;
      e_redir = (upd_valid && upd_taken) ? upd_target : upd_pc + 32'd4;
      check("lk_taken", {31'b0, lk_taken}, {31'b0, e_taken});
      check("lk_next_pc", lk_next_pc, e_next);
      check("mispredict", {31'b0, mispredict}, {31'b0, model_mp()});
      check("redirect_pc", redirect_pc, e_redir);
      check("stat_updates", stat_updates, stat_view(m_upd));
      check("stat_mispredicts", stat_mispredicts, stat_view(m_mis));
      if (lit_lk_en) begin
        check("lit_lk_taken", {31'b0, lk_taken}, {31'b0, lit_lk_taken});
        check("lit_lk_next_pc", lk_next_pc, lit_lk_next);
      end
      if (lit_mp_en) begin
        check("lit_mispredict", {31'b0, mispredict}, {31'b0, lit_mp});
        check("lit_redirect_pc", redirect_pc, lit_redir);
      end
      if (lit_st_en) begin
        check("lit_stat_updates", stat_updates, lit_st_upd);
        check("lit_stat_mispredicts", stat_mispredicts, lit_st_mis);
      end
      if (upd_valid)
        $display("upd pc=%h taken=%0d target=%h clear=%0d -> mispredict=%0d redirect=%h",
                 upd_pc, upd_taken, upd_target, bp_clear, mispredict, redirect_pc);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    rst       = 1'b0;
    bp_clear  = 1'b0;
    upd_valid = 1'b0;
    lit_lk_en = 0;
    lit_mp_en = 0;
    lit_st_en = 0;
  endtask

  task automatic upd(input logic [31:0] pc, input logic t, input logic [31:0] tg,
                     input logic pt, input logic [31:0] ptg);
    upd_valid       = 1'b1;
    upd_pc          = pc;
    upd_taken       = t;
    upd_target      = tg;
    upd_pred_taken  = pt;
    upd_pred_target = ptg;
  endtask

  task automatic exp_lk(input logic t, input logic [31:0] nxt);
    lit_lk_en = 1; lit_lk_taken = t; lit_lk_next = nxt;
  endtask

  task automatic exp_mp(input logic m, input logic [31:0] r);
    lit_mp_en = 1; lit_mp = m; lit_redir = r;
  endtask

  task automatic exp_st(input logic [31:0] u, input logic [31:0] m);
    lit_st_en = 1; lit_st_upd = stat_view(u); lit_st_mis = stat_view(m);
  endtask

  initial begin
    rst = 1'b1; bp_clear = 1'b0; lk_pc = 32'h40;
    upd_valid = 1'b0; upd_pc = 32'h0; upd_taken = 1'b0; upd_target = 32'h0;
    upd_pred_taken = 1'b0; upd_pred_target = 32'h0;
    @(posedge clk); #1;
    tick();

    // 1: empty table after reset; idle update port still reports pc+4, no mispredict
    lk_pc = 32'h40; exp_lk(0, 32'h44); exp_st(0, 0);
    upd_pc = 32'h10; upd_taken = 1'b1; upd_target = 32'h999; upd_pred_taken = 1'b0;
    exp_mp(0, 32'h14);
    tick();

    // 2: taken miss allocates weakly taken
    upd(32'h40, 1, 32'h80, 0, 32'h44); exp_mp(1, 32'h80); exp_lk(0, 32'h44); tick();
    exp_lk(1, 32'h80); tick();

    // 3: counter walks down, saturates at 0, then back up and saturates at max
    upd(32'h40, 0, 32'h0, 1, 32'h80); exp_mp(1, 32'h44); tick();
    exp_lk(0, 32'h44); upd(32'h40, 0, 32'h0, 0, 32'h44); exp_mp(0, 32'h44); tick();
    upd(32'h40, 0, 32'h0, 0, 32'h44); tick();
    upd(32'h40, 1, 32'h80, 0, 32'h44); exp_mp(1, 32'h80); tick();
    exp_lk(0, 32'h44); upd(32'h40, 1, 32'h80, 0, 32'h44); tick();
    exp_lk(1, 32'h80); upd(32'h40, 1, 32'h84, 1, 32'h80); exp_mp(1, 32'h84); tick();
    upd(32'h40, 1, 32'h84, 1, 32'h84); exp_mp(0, 32'h84); tick();
    upd(32'h40, 0, 32'h0, 1, 32'h84); exp_mp(1, 32'h44); tick();
    exp_lk(1, 32'h84); tick();

    // 4: aliasing at index 0 (0x40 tag 1 vs 0x80 tag 2)
    lk_pc = 32'h80; exp_lk(0, 32'h84); upd(32'h80, 1, 32'h100, 0, 32'h84); tick();
    exp_lk(1, 32'h100); tick();
    lk_pc = 32'h40; exp_lk(0, 32'h44); tick();
    lk_pc = 32'hFFFF_FFFC; exp_lk(0, 32'h0); tick();

    // 5: same-cycle lookup/update, then clear beats a simultaneous allocation
    bp_clear = 1'b1; tick();
    lk_pc = 32'h40; upd(32'h40, 1, 32'hC0, 0, 32'h44); exp_lk(0, 32'h44); tick();
    exp_lk(1, 32'hC0); tick();
    bp_clear = 1'b1; upd(32'h200, 1, 32'h300, 0, 32'h204); tick();
    lk_pc = 32'h200; exp_lk(0, 32'h204); tick();
    lk_pc = 32'h40; exp_lk(0, 32'h44); tick();

    // 6: statistics: 5 updates, 2 mispredicted; bp_clear keeps them, rst zeroes them
    rst = 1'b1; tick();
    exp_st(0, 0); tick();
    upd(32'h10, 1, 32'h20, 0, 32'h14); tick();
    upd(32'h10, 1, 32'h20, 1, 32'h20); tick();
    upd(32'h14, 0, 32'h0, 0, 32'h18); tick();
    upd(32'h18, 0, 32'h0, 1, 32'h30); tick();
    upd(32'h10, 1, 32'h20, 1, 32'h20); tick();
    exp_st(5, 2); bp_clear = 1'b1; tick();
    exp_st(5, 2); tick();
    rst = 1'b1; tick();
    exp_st(0, 0); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
